// File: rtl/mem_pkg.sv
// Shared types and width helpers for the pipelined two-port synchronous memory.
package mem_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_INIT  = 2'd1,
    ST_READY = 2'd2
  } init_st_e;

  function automatic int ben_w(input int dw);
    return dw / BYTE_W;
  endfunction

  function automatic int data_w(input int bw);
    return bw * BYTE_W;
  endfunction

endpackage

// File: rtl/mem_init_ctrl.sv
// Post-reset sweep controller: owns the write port while zeroing the array,
// then raises o_ready. All outputs are registered.
module mem_init_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH     = 2048,
  parameter int INIT_ZERO = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     o_ready,
  output logic                     o_init_sel,
  output logic [$clog2(DEPTH)-1:0] o_init_addr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  init_st_e        r_state;
  logic [AW-1:0]   r_cnt;
  logic            r_sel;
  logic            r_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RESET;
      r_cnt   <= '0;
      r_sel   <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_RESET: begin
          if (INIT_ZERO != 0) begin
            r_state <= ST_INIT;
            r_sel   <= 1'b1;
          end else begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
          end
        end
        ST_INIT: begin
          // Counter stops on the last word instead of wrapping.
          if (r_cnt == LAST) begin
            r_state <= ST_READY;
            r_sel   <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_READY: ;
        default: begin
          r_state <= ST_RESET;
          r_sel   <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready     = r_ready;
  assign o_init_sel  = r_sel;
  assign o_init_addr = r_cnt;

endmodule

// File: rtl/mem_sync_2p_pipe.sv
// Two-port (1W/1R) synchronous memory with byte enables, optional output register
// and post-reset zero sweep. Define MEM_COLLISION_BYPASS_EN for write-first collisions.
module mem_sync_2p_pipe
  import mem_pkg::*;
#(
  parameter int DEPTH      = 2048,
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0,
  parameter int INIT_ZERO  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         o_ready,
  input  logic [$clog2(DEPTH)-1:0]     i_wr_addr,
  input  logic [DATA_WIDTH-1:0]        i_wr_data,
  input  logic [DATA_WIDTH/BYTE_W-1:0] i_wr_ben,
  input  logic                         i_rd_en,
  input  logic [$clog2(DEPTH)-1:0]     i_rd_addr,
  output logic [DATA_WIDTH-1:0]        o_rd_data,
  output logic                         o_rd_valid
);

  localparam int AW     = $clog2(DEPTH);
  localparam int BEN_W  = ben_w(DATA_WIDTH);
  localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

  logic                  w_init_sel;
  logic [AW-1:0]         w_init_addr;
  logic [BEN_W-1:0]      w_we;
  logic [AW-1:0]         w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_rd_acc;
  logic [DATA_WIDTH-1:0] w_rd_word;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_q;
  logic [STAGES:1]       r_vld_pipe;

  mem_init_ctrl #(
    .DEPTH     (DEPTH),
    .INIT_ZERO (INIT_ZERO)
  ) u_init (
    .clk         (clk),
    .rst_n       (rst_n),
    .o_ready     (o_ready),
    .o_init_sel  (w_init_sel),
    .o_init_addr (w_init_addr)
  );

  // Sweep takes the write port; user writes only land once ready.
  assign w_we     = w_init_sel ? {BEN_W{1'b1}} : (o_ready ? i_wr_ben : '0);
  assign w_waddr  = w_init_sel ? w_init_addr : i_wr_addr;
  assign w_wdata  = w_init_sel ? '0 : i_wr_data;
  assign w_rd_acc = i_rd_en & o_ready;

  always_ff @(posedge clk) begin
    for (int b = 0; b < BEN_W; b++) begin
      if (w_we[b]) r_mem[w_waddr][b*BYTE_W +: BYTE_W] <= w_wdata[b*BYTE_W +: BYTE_W];
    end
  end

`ifdef MEM_COLLISION_BYPASS_EN
  always_comb begin
    w_rd_word = r_mem[i_rd_addr];
    if (i_wr_addr == i_rd_addr) begin
      for (int b = 0; b < BEN_W; b++) begin
        if (w_we[b]) w_rd_word[b*BYTE_W +: BYTE_W] = i_wr_data[b*BYTE_W +: BYTE_W];
      end
    end
  end
`else
  assign w_rd_word = r_mem[i_rd_addr];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_q     <= '0;
      r_vld_pipe <= '0;
    end else begin
      if (w_rd_acc) r_rd_q <= w_rd_word;
      r_vld_pipe[1] <= w_rd_acc;
      for (int s = 2; s <= STAGES; s++) r_vld_pipe[s] <= r_vld_pipe[s-1];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] r_out;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             r_out <= '0;
        else if (r_vld_pipe[1]) r_out <= r_rd_q;
      end
      assign o_rd_data = r_out;
    end else begin : g_noreg
      assign o_rd_data = r_rd_q;
    end
  endgenerate

  assign o_rd_valid = r_vld_pipe[STAGES];

endmodule

// File: tb/tb_mem_sync_2p_pipe.sv
// Randomised bench for mem_sync_2p_pipe: OUT_REG=0 and OUT_REG=1 instances share
// stimulus and are checked every cycle against a word-array/queue model.
module tb_mem_sync_2p_pipe;

  localparam int DEPTH    = 2048;
  localparam int READY_AT = DEPTH + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] wa = '0, ra = '0;
  logic [31:0] wd = '0;
  logic [3:0]  ben = '0;
  logic        re = 1'b0;

  logic        rdy0, rdy1, rdv0, rdv1;
  logic [31:0] rdd0, rdd1;

  always #5 clk = ~clk;

  mem_sync_2p_pipe #(.DEPTH(DEPTH), .DATA_WIDTH(32), .OUT_REG(0), .INIT_ZERO(1)) u0 (
    .clk(clk), .rst_n(rst_n), .o_ready(rdy0), .i_wr_addr(wa), .i_wr_data(wd),
    .i_wr_ben(ben), .i_rd_en(re), .i_rd_addr(ra), .o_rd_data(rdd0), .o_rd_valid(rdv0));

  mem_sync_2p_pipe #(.DEPTH(DEPTH), .DATA_WIDTH(32), .OUT_REG(1), .INIT_ZERO(1)) u1 (
    .clk(clk), .rst_n(rst_n), .o_ready(rdy1), .i_wr_addr(wa), .i_wr_data(wd),
    .i_wr_ben(ben), .i_rd_en(re), .i_rd_addr(ra), .o_rd_data(rdd1), .o_rd_valid(rdv1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: ready 2049 edges after release, contents zero, reads due 1/2 edges later.
  typedef struct { logic [31:0] d; int due; } exp_t;
  exp_t        q0[$], q1[$];
  logic [31:0] m_mem [DEPTH];
  int          m_cyc = 0;
  int          ecnt = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_cyc = 0;
      q0.delete();
      q1.delete();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else begin
      ecnt++;
      if (m_cyc >= READY_AT) begin
        if (re) begin
          logic [31:0] w;
          w = m_mem[ra];
`ifdef MEM_COLLISION_BYPASS_EN
          if (wa == ra)
            for (int b = 0; b < 4; b++) if (ben[b]) w[b*8 +: 8] = wd[b*8 +: 8];
`endif
          q0.push_back('{w, ecnt});
          q1.push_back('{w, ecnt + 1});
        end
        for (int b = 0; b < 4; b++) if (ben[b]) m_mem[wa][b*8 +: 8] = wd[b*8 +: 8];
      end
      m_cyc++;
    end
  end

  logic [31:0] last0 = '0, last1 = '0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_ready", {30'd0, rdy1, rdy0}, 32'd0);
      chk("rst_valid", {30'd0, rdv1, rdv0}, 32'd0);
      chk("rst_data0", rdd0, 32'd0);
      chk("rst_data1", rdd1, 32'd0);
      last0 = '0;
      last1 = '0;
    end else begin
      logic e0, e1;
      exp_t e;
      chk("ready", {30'd0, rdy1, rdy0}, (m_cyc >= READY_AT) ? 32'd3 : 32'd0);
      while (q0.size() > 0 && q0[0].due < ecnt) void'(q0.pop_front());
      while (q1.size() > 0 && q1[0].due < ecnt) void'(q1.pop_front());
      e0 = q0.size() > 0 && q0[0].due == ecnt;
      e1 = q1.size() > 0 && q1[0].due == ecnt;
      chk("valid0", {31'd0, rdv0}, {31'd0, e0});
      chk("valid1", {31'd0, rdv1}, {31'd0, e1});
      if (e0) begin e = q0.pop_front(); chk("data0", rdd0, e.d); last0 = e.d; end
      else chk("hold0", rdd0, last0);
      if (e1) begin e = q1.pop_front(); chk("data1", rdd1, e.d); last1 = e.d; end
      else chk("hold1", rdd1, last1);
    end
  end

  task automatic drive(input logic [10:0] a_w, input logic [31:0] d_w, input logic [3:0] b_w,
                       input logic r_e, input logic [10:0] a_r);
    @(negedge clk);
    wa = a_w; wd = d_w; ben = b_w; re = r_e; ra = a_r;
  endtask

  task automatic idle();
    drive(11'd0, 32'd0, 4'd0, 1'b0, 11'd0);
  endtask

  task automatic rd_lit(input string nm, input logic [10:0] a, input logic [31:0] exp);
    drive(11'd0, 32'd0, 4'd0, 1'b1, a);
    idle();
    chk({nm, "_v0"}, {31'd0, rdv0}, 32'd1);
    chk({nm, "_d0"}, rdd0, exp);
    idle();
    chk({nm, "_v1"}, {31'd0, rdv1}, 32'd1);
    chk({nm, "_d1"}, rdd1, exp);
  endtask

  task automatic release_wait(input bit poke);
    int  n;
    bit  done;
    @(negedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done && n < 3000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (poke && n == 5) begin
        wa = 11'd9; wd = 32'h1; ben = 4'hF; re = 1'b1; ra = 11'd9;
      end
      if (poke && n == 6) begin
        wa = '0; wd = '0; ben = '0; re = 1'b0; ra = '0;
        chk("drop_valid", {30'd0, rdv1, rdv0}, 32'd0);
      end
      if (rdy0) done = 1'b1;
    end
    chk("ready_latency", n, 32'd2049);
    chk("ready_both", {30'd0, rdy1, rdy0}, 32'd3);
  endtask

  task automatic assert_reset_now(input string nm);
    #2 rst_n = 1'b0;
    #1;
    chk({nm, "_ready"}, {30'd0, rdy1, rdy0}, 32'd0);
    chk({nm, "_valid"}, {30'd0, rdv1, rdv0}, 32'd0);
    chk({nm, "_data0"}, rdd0, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [5:0]  pat0, pat1;
    logic [31:0] dat0 [6];
    repeat (3) @(negedge clk);

    // Startup sweep; a write+read poked while not ready must vanish.
    release_wait(1'b1);
    rd_lit("dropped_addr9", 11'd9, 32'h0000_0000);

    // Byte enables.
    drive(11'd5, 32'hFFFF_FFFF, 4'hF, 1'b0, 11'd0);
    drive(11'd5, 32'h1234_5678, 4'h5, 1'b0, 11'd0);
    drive(11'd6, 32'hCAFE_F00D, 4'h0, 1'b0, 11'd0);
    rd_lit("ben_addr5", 11'd5, 32'hFF34_FF78);
    rd_lit("ben0_addr6", 11'd6, 32'h0000_0000);

    // Latency: four back-to-back reads.
    for (int i = 0; i < 4; i++) drive(11'(i), 32'hC0DE_0000 + i, 4'hF, 1'b0, 11'd0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k > 0) begin
        pat0[k-1] = rdv0;
        pat1[k-1] = rdv1;
        dat0[k-1] = rdd0;
      end
      re = (k < 4);
      ra = 11'(k);
    end
    re = 1'b0; ra = '0;
    chk("lat_pat0", {26'd0, pat0}, 32'h0F);
    chk("lat_pat1", {26'd0, pat1}, 32'h1E);
    chk("lat_first0", dat0[0], 32'hC0DE_0000);
    chk("lat_last0", dat0[3], 32'hC0DE_0003);

    // Same-cycle write and read of one address.
    drive(11'd7, 32'hAAAA_AAAA, 4'hF, 1'b0, 11'd0);
    drive(11'd7, 32'h5555_5555, 4'h3, 1'b1, 11'd7);
    idle();
`ifdef MEM_COLLISION_BYPASS_EN
    chk("collision", rdd0, 32'hAAAA_5555);
`else
    chk("collision", rdd0, 32'hAAAA_AAAA);
`endif
    rd_lit("after_coll", 11'd7, 32'hAAAA_5555);

    // Random traffic, biased to a few addresses to provoke collisions.
    for (int c = 0; c < 800; c++) begin
      logic [10:0] aw, ar;
      aw = $urandom_range(0, 1) ? 11'($urandom_range(0, 15)) : 11'($urandom_range(0, DEPTH - 1));
      ar = $urandom_range(0, 2) != 0 ? 11'($urandom_range(0, 15)) : 11'($urandom_range(0, DEPTH - 1));
      drive(aw, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ar);
    end
    idle(); idle(); idle();

    // Garbage then reset with a read in flight.
    drive(11'd0,    32'hDEAD_BEEF, 4'hF, 1'b0, 11'd0);
    drive(11'd1023, 32'hDEAD_BEEF, 4'hF, 1'b0, 11'd0);
    drive(11'd2047, 32'hDEAD_BEEF, 4'hF, 1'b1, 11'd5);
    idle();
    assert_reset_now("rst_inflight");
    release_wait(1'b0);
    rd_lit("init_a0", 11'd0, 32'h0);
    rd_lit("init_a1023", 11'd1023, 32'h0);
    rd_lit("init_a2047", 11'd2047, 32'h0);

    // Reset in the middle of the sweep (counter at 100).
    drive(11'd50,  32'h1111_1111, 4'hF, 1'b0, 11'd0);
    drive(11'd100, 32'h2222_2222, 4'hF, 1'b0, 11'd0);
    idle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (101) @(posedge clk);
    @(negedge clk);
    assert_reset_now("rst_midinit");
    release_wait(1'b0);
    rd_lit("restart_a50", 11'd50, 32'h0);
    rd_lit("restart_a100", 11'd100, 32'h0);
    idle(); idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_sync_2p_pipe.md
MEM_SYNC_2P_PIPE -- requirements
Module: mem_sync_2p_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 2048, number of words; power of two, >=2.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; multiple of 8.
REQ-003 SHALL have parameter OUT_REG, default 0, 1 adds an output register stage to the read path.
REQ-004 SHALL have parameter INIT_ZERO, default 1, 1 clears the array with a hardware sweep after reset.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port o_ready  output  1  array usable; low during reset and the init sweep.
REQ-008 SHALL have port i_wr_addr  input  $clog2(DEPTH)  write address.
REQ-009 SHALL have port i_wr_data  input  DATA_WIDTH  write data.
REQ-010 SHALL have port i_wr_ben  input  DATA_WIDTH/8  byte write enables; bit k writes byte k.
REQ-011 SHALL have port i_rd_en  input  1  read request.
REQ-012 SHALL have port i_rd_addr  input  $clog2(DEPTH)  read address.
REQ-013 SHALL have port o_rd_data  output  DATA_WIDTH  read data, qualified by o_rd_valid.
REQ-014 SHALL have port o_rd_valid  output  1  o_rd_data holds the result of an accepted read.

Function
REQ-015 SHALL accept writes and reads only in cycles where o_ready=1; requests while o_ready=0 are dropped with no side effect.
REQ-016 SHALL update only bytes whose i_wr_ben bit is 1; i_wr_ben=0 is a no-op.
REQ-017 SHALL return read data with o_rd_valid=1 exactly 1 cycle after acceptance (OUT_REG=0) or 2 cycles (OUT_REG=1); back-to-back reads pipeline at one per cycle.
REQ-018 SHALL hold o_rd_data at its last value while o_rd_valid=0.
REQ-019 SHALL treat the write and read ports as independent; both may be accepted in the same cycle.
REQ-020 SHALL implement an init FSM with states RESET, INIT, READY: RESET->INIT at first clock after rst_n release if INIT_ZERO=1, else RESET->READY.
REQ-021 SHALL in INIT write zero to one address per cycle from 0 to DEPTH-1, then go to READY; o_ready=1 from the cycle after the last init write.
REQ-022 SHALL block user writes during INIT (sweep owns the write port).
REQ-023 SHALL wrap no address; the sweep counter terminates at DEPTH-1.

Reset
REQ-024 SHALL on rst_n=0 immediately force o_ready=0, o_rd_valid=0 (all pipe stages), o_rd_data=0, FSM=RESET, sweep counter=0.
REQ-025 SHALL not reset array contents by rst_n; only the INIT sweep clears them.
REQ-026 SHALL on reset asserted mid-INIT restart the sweep from address 0 after release; in-flight reads are discarded.

Configuration
REQ-027 SHALL honour macro MEM_COLLISION_BYPASS_EN: defined -> same-cycle read and write to the same address return write-first data (enabled bytes new, others old); undefined -> read-first (old word returned).

Structure
REQ-028 SHALL place the FSM state enum, the byte-width constant (8) and the data/ben width helper functions in shared package mem_pkg.
REQ-029 SHALL implement the sweep FSM and counter in sub-module mem_init_ctrl, which drives the write-port mux select, address and o_ready.

Verification
REQ-030 SHALL cover init: INIT_ZERO=1, DEPTH=2048, pre-load garbage then reset -> o_ready rises 2049 cycles after rst_n release (RESET cycle plus 2048 sweep cycles); reads of 0, 1023, 2047 return 0x00000000.
REQ-031 SHALL cover byte enables: write 0xFFFFFFFF to addr 5, then 0x12345678 with ben=0x5 -> read addr 5 returns 0xFF34FF78.
REQ-032 SHALL cover latency: reads of addrs 0..3 on consecutive cycles with OUT_REG=0 and 1 -> o_rd_valid high for 4 consecutive cycles starting 1 or 2 cycles after the first request respectively, data in order.
REQ-033 SHALL cover collision: addr 7 holds 0xAAAAAAAA, same-cycle write 0x55555555 ben=0x3 and read addr 7 -> 0xAAAA5555 with MEM_COLLISION_BYPASS_EN, 0xAAAAAAAA without.
REQ-034 SHALL cover reset mid-INIT: assert rst_n=0 at sweep address 100 -> o_ready and o_rd_valid drop the same instant; after release the sweep restarts at 0 and takes the full 2049 cycles.
REQ-035 SHALL cover dropped requests: write 0x1 to addr 9 and read addr 9 while o_ready=0 -> no o_rd_valid; after READY, addr 9 reads 0x00000000.
